clken_nco: RTL and testbench
============================

CLKEN_NCO -- requirements
Module: clken_nco

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 24, phase accumulator and increment width in bits (8..32).
REQ-003 SHALL have parameter LOCK_CYC, default 256, number of clk cycles from reset release to lock (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port inc_wr  input  1  one-cycle strobe that writes inc_val to channel inc_ch.
REQ-007 SHALL have port inc_ch  input  max(1,$clog2(NCH))  target channel index for inc_wr.
REQ-008 SHALL have port inc_val  input  ACC_W  new phase increment.
REQ-009 SHALL have port ch_en  input  NCH  per-channel run enable.
REQ-010 SHALL have port tick  output  NCH  per-channel one-cycle enable pulse.
REQ-011 SHALL have port sq  output  NCH  per-channel square wave (present only under the configuration macro).
REQ-012 SHALL have port lock  output  1  high once the startup interval has elapsed.

Function
REQ-013 SHALL keep, per channel i, registers acc[i] and inc[i], each ACC_W bits wide.
REQ-014 SHALL compute acc[i] + inc[i] at ACC_W+1 bits when lock=1 and ch_en[i]=1, store the low ACC_W bits in acc[i], and register the carry into tick[i] (tick appears the cycle after the overflowing add).
REQ-015 SHALL give an average tick rate of f_clk*inc[i]/2^ACC_W; with inc[i]=0, tick[i] SHALL never assert.
REQ-016 SHALL hold acc[i] and force tick[i]=0 while ch_en[i]=0 or lock=0.
REQ-017 SHALL, on inc_wr=1 with inc_ch<NCH, set inc[inc_ch]<=inc_val and acc[inc_ch]<=0 on that edge, with tick[inc_ch]=0 the following cycle (phase realignment).
REQ-018 SHALL give a write priority over the same-cycle add for the addressed channel; all other channels SHALL advance normally.
REQ-019 SHALL ignore inc_wr when inc_ch>=NCH, leaving no state change.
REQ-020 SHALL implement lock with a counter that starts at 0 after reset and saturates; lock SHALL rise on the edge LOCK_CYC cycles after the first cycle with reset=0 and then stay high until reset.
REQ-021 SHALL accept increment writes before lock, so the first ticks after lock use the written values.

Reset
REQ-022 SHALL, while reset=1 on an edge, clear acc, tick, sq, lock and the lock counter to 0, and set inc to 0.
REQ-023 SHALL allow reset mid-operation to abort all channels immediately; no tick SHALL follow a reset cycle.

Configuration
REQ-024 SHALL honour macro CLKEN_NCO_SQUARE_EN: when it is defined, sq[i] SHALL toggle on the edge where tick[i] is registered high (a 50%-average square wave at half the tick rate) and clear on reset or on a write to channel i.
REQ-025 SHALL, when CLKEN_NCO_SQUARE_EN is undefined, omit the sq port and its registers entirely; tick and lock behaviour SHALL be unchanged.

Structure
REQ-026 SHALL take default constants (NCH, ACC_W, LOCK_CYC defaults, maximum NCH) from package clken_nco_pkg.
REQ-027 SHALL instantiate one sub-module clken_nco_ch per channel, holding acc, inc, tick and sq; the top level SHALL hold the lock counter and write decode.

Verification (NCH=2, ACC_W=24, LOCK_CYC=16 unless stated)
REQ-028 SHALL cover: reset for 3 cycles, then release -> lock=0 for 16 cycles, lock=1 on edge 16, tick=0 throughout.
REQ-029 SHALL cover: write ch0 inc=0x800000 before lock, ch_en=2'b01 -> after lock, tick[0] pulses every 2nd cycle, tick[1]=0; with SQUARE_EN, sq[0] period is 4 cycles.
REQ-030 SHALL cover: ch1 inc=0x555556, run 3000 cycles -> exactly 1000 tick[1] pulses (+-1), with gaps of 2 or 3 cycles and never 0 or 1.
REQ-031 SHALL cover: inc_wr to ch0 in the cycle before an expected overflow -> acc[0]=0 and no tick the next cycle, ch1 ticks are undisturbed, and inc_ch=2 produces no change.
REQ-032 SHALL cover: ch_en[0] dropped for 5 cycles mid-run -> tick[0] stays 0 and the phase resumes exactly where it stopped (tick schedule shifted by 5 cycles).
REQ-033 SHALL cover: reset asserted for 1 cycle during active ticking -> all outputs 0 the next cycle, and lock re-qualifies after 16 cycles.

Source files
------------

// File: rtl/clken_nco_pkg.sv
// Shared constants and types for the clken_nco clock-enable NCO.
// Optional feature macro: CLKEN_NCO_SQUARE_EN adds per-channel square outputs.
package clken_nco_pkg;

  localparam int unsigned NCH_DEF      = 2;
  localparam int unsigned NCH_MAX      = 8;
  localparam int unsigned ACC_W_DEF    = 24;
  localparam int unsigned LOCK_CYC_DEF = 256;

  // Startup qualification state
  typedef enum logic {
    LK_WAIT   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  // Index width for n items, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clken_nco_ch.sv
// One NCO channel: phase accumulator, increment register, tick pulse and
// (with CLKEN_NCO_SQUARE_EN) a square wave toggling on every tick.
module clken_nco_ch
  import clken_nco_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_val,
`ifdef CLKEN_NCO_SQUARE_EN
  output logic             o_sq,
`endif
  output logic             o_tick
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic             r_tick;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  // Accumulate while running; a write realigns phase and wins over the add
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_inc  <= '0;
      r_tick <= 1'b0;
    end else if (i_wr) begin
      r_inc  <= i_val;
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (i_run) begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_tick <= w_sum[ACC_W];
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

`ifdef CLKEN_NCO_SQUARE_EN
  logic r_sq;

  // Toggle on the same edge that registers a tick high
  always_ff @(posedge clk) begin
    if (reset || i_wr) begin
      r_sq <= 1'b0;
    end else if (i_run && w_sum[ACC_W]) begin
      r_sq <= ~r_sq;
    end
  end

  assign o_sq = r_sq;
`endif

endmodule

// File: rtl/clken_nco.sv
// Multi-channel clock-enable NCO with a startup lock interval.
// Optional feature macro: CLKEN_NCO_SQUARE_EN adds the sq output port.
module clken_nco
  import clken_nco_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned LOCK_CYC = LOCK_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_wr,
  input  logic [idx_w(NCH)-1:0] inc_ch,
  input  logic [ACC_W-1:0]      inc_val,
  input  logic [NCH-1:0]        ch_en,
  output logic [NCH-1:0]        tick,
`ifdef CLKEN_NCO_SQUARE_EN
  output logic [NCH-1:0]        sq,
`endif
  output logic                  lock
);

  localparam int unsigned CH_W  = idx_w(NCH);
  localparam int unsigned CNT_W = idx_w(LOCK_CYC);

  lock_state_e      r_lk_state;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             w_lock;

  // Count cycles since reset release; lock once LOCK_CYC edges have elapsed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lk_state <= LK_WAIT;
      r_lock_cnt <= '0;
    end else begin
      case (r_lk_state)
        LK_WAIT: begin
          if (r_lock_cnt == CNT_W'(LOCK_CYC - 1)) begin
            r_lk_state <= LK_LOCKED;
          end else begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
          end
        end
        LK_LOCKED: r_lk_state <= LK_LOCKED;
      endcase
    end
  end

  assign w_lock = (r_lk_state == LK_LOCKED);
  assign lock   = w_lock;

  // Per-channel write decode and channel instances; out-of-range indices match nothing
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic w_wr;
    logic w_run;

    assign w_wr  = inc_wr && (inc_ch == CH_W'(i));
    assign w_run = w_lock && ch_en[i];

    clken_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .i_run  (w_run),
      .i_wr   (w_wr),
      .i_val  (inc_val),
`ifdef CLKEN_NCO_SQUARE_EN
      .o_sq   (sq[i]),
`endif
      .o_tick (tick[i])
    );
  end

endmodule

// File: tb/tb_clken_nco.sv
// Directed bench for clken_nco: startup/lock table plus hand-written
// sequences for realignment, enable gating, rate, reset abort and write decode.
module tb_clken_nco;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc_wr;
  logic [0:0]  inc_ch;
  logic [23:0] inc_val;
  logic [1:0]  ch_en;
  logic [1:0]  tick;
  logic        lock;
`ifdef CLKEN_NCO_SQUARE_EN
  logic [1:0]  sq;
  logic [2:0]  sq3;
`endif

  // Second instance with three channels so an out-of-range index is expressible
  logic        inc_wr3;
  logic [1:0]  inc_ch3;
  logic [7:0]  inc_val3;
  logic [2:0]  ch_en3;
  logic [2:0]  tick3;
  logic        lock3;

  always #5 clk = ~clk;

  clken_nco #(.NCH(2), .ACC_W(24), .LOCK_CYC(16)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .inc_wr  (inc_wr),
    .inc_ch  (inc_ch),
    .inc_val (inc_val),
    .ch_en   (ch_en),
    .tick    (tick),
`ifdef CLKEN_NCO_SQUARE_EN
    .sq      (sq),
`endif
    .lock    (lock)
  );

  clken_nco #(.NCH(3), .ACC_W(8), .LOCK_CYC(4)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .inc_wr  (inc_wr3),
    .inc_ch  (inc_ch3),
    .inc_val (inc_val3),
    .ch_en   (ch_en3),
    .tick    (tick3),
`ifdef CLKEN_NCO_SQUARE_EN
    .sq      (sq3),
`endif
    .lock    (lock3)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [0:0]  ch;
    logic [23:0] val;
    logic [1:0]  en;
    logic [1:0]  exp_tick;
    logic        exp_lock;
    logic [1:0]  exp_sq;
  } vec_t;

  vec_t vtab[27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Drive one cycle of inputs, then check tick and lock after the edge
  task automatic step(input string nm, input logic rst, input logic wr, input logic [0:0] ch,
                      input logic [23:0] val, input logic [1:0] en,
                      input logic [1:0] exp_t, input logic exp_l);
    reset = rst; inc_wr = wr; inc_ch = ch; inc_val = val; ch_en = en;
    @(posedge clk); #1;
    chk({nm, "_tick"}, 32'(tick), 32'(exp_t));
    chk({nm, "_lock"}, 32'(lock), 32'(exp_l));
    inc_wr = 1'b0;
  endtask

  int cnt0, cnt1, last, first, gmin, gmax;
  logic [1:0] e2;

  initial begin
    reset = 1'b1; inc_wr = 1'b0; inc_ch = '0; inc_val = '0; ch_en = '0;
    inc_wr3 = 1'b0; inc_ch3 = '0; inc_val3 = '0; ch_en3 = 3'b111;

    // Startup table: 3 reset cycles, write ch0 on first free cycle, lock at edge 16,
    // then ch0 ticks on even edges from 18 and sq[0] has a 4-cycle period
    for (int k = 0; k < 3; k++) begin
      vtab[k] = '{rst: 1'b1, wr: 1'b0, ch: 1'b0, val: 24'h0, en: 2'b01,
                  exp_tick: 2'b00, exp_lock: 1'b0, exp_sq: 2'b00};
    end
    for (int e = 1; e <= 24; e++) begin
      vtab[e+2].rst      = 1'b0;
      vtab[e+2].wr       = (e == 1);
      vtab[e+2].ch       = 1'b0;
      vtab[e+2].val      = 24'h800000;
      vtab[e+2].en       = 2'b01;
      vtab[e+2].exp_lock = (e >= 16);
      vtab[e+2].exp_tick = (e >= 18 && (e % 2) == 0) ? 2'b01 : 2'b00;
      vtab[e+2].exp_sq   = (e >= 18 && (((e - 18) / 2) % 2) == 0) ? 2'b01 : 2'b00;
    end

    for (int k = 0; k < 27; k++) begin
      reset = vtab[k].rst; inc_wr = vtab[k].wr; inc_ch = vtab[k].ch;
      inc_val = vtab[k].val; ch_en = vtab[k].en;
      @(posedge clk); #1;
      chk($sformatf("tab%0d_tick", k), 32'(tick), 32'(vtab[k].exp_tick));
      chk($sformatf("tab%0d_lock", k), 32'(lock), 32'(vtab[k].exp_lock));
`ifdef CLKEN_NCO_SQUARE_EN
      chk($sformatf("tab%0d_sq", k), 32'(sq), 32'(vtab[k].exp_sq));
`endif
    end
    inc_wr = 1'b0;

    // Write to ch0 on the edge of its overflow: tick suppressed, ch1 unaffected
    step("s31_0",  1'b0, 1'b1, 1'b0, 24'h800000, 2'b00, 2'b00, 1'b1);
    step("s31_1",  1'b0, 1'b1, 1'b1, 24'h800000, 2'b00, 2'b00, 1'b1);
    step("s31_2",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_3",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b11, 1'b1);
    step("s31_4",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_5",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b11, 1'b1);
    step("s31_6",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_7",  1'b0, 1'b1, 1'b0, 24'h400000, 2'b11, 2'b10, 1'b1);
`ifdef CLKEN_NCO_SQUARE_EN
    chk("s31_sq_clear", 32'(sq), 32'(2'b10));
`endif
    step("s31_8",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_9",  1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b10, 1'b1);
    step("s31_10", 1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_11", 1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b11, 1'b1);
    step("s31_12", 1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_13", 1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b10, 1'b1);
    step("s31_14", 1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b00, 1'b1);
    step("s31_15", 1'b0, 1'b0, 1'b0, 24'h0,      2'b11, 2'b11, 1'b1);

    // ch0 period 4; enable dropped on edges 6..10 shifts ticks from 8,12 to 13,17
    for (int e = 0; e <= 17; e++) begin
      e2 = (e == 4 || e == 13 || e == 17) ? 2'b01 : 2'b00;
      step($sformatf("s32_%0d", e), 1'b0, (e == 0), 1'b0, 24'h400000,
           (e >= 6 && e <= 10) ? 2'b00 : 2'b01, e2, 1'b1);
    end

    // ch1 at 1/3 rate for 3000 cycles: ~1000 ticks, gaps 2..3, first tick on edge 3
    step("s30_wr", 1'b0, 1'b1, 1'b1, 24'h555556, 2'b10, 2'b00, 1'b1);
    cnt0 = 0; cnt1 = 0; last = -1; first = -1; gmin = 1000; gmax = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      if (tick[0]) cnt0++;
      if (tick[1]) begin
        if (last >= 0) begin
          if (c - last < gmin) gmin = c - last;
          if (c - last > gmax) gmax = c - last;
        end else begin
          first = c;
        end
        last = c;
        cnt1++;
      end
    end
    chk_rng("s30_count", cnt1, 999, 1001);
    chk_rng("s30_gap_min", gmin, 2, 3);
    chk_rng("s30_gap_max", gmax, 2, 3);
    chk_rng("s30_first", first, 3, 3);
    chk("s30_ch0_idle", 32'(cnt0), 32'd0);

    // Reset on an edge where ch1 would tick; everything clears and lock re-qualifies
    step("s33_1", 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 2'b00, 1'b1);
    step("s33_2", 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 2'b00, 1'b1);
    step("s33_3", 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 2'b10, 1'b1);
    step("s33_4", 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 2'b01, 1'b1);
    step("s33_5", 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 2'b00, 1'b1);
    step("s33_rst", 1'b1, 1'b0, 1'b0, 24'h0, 2'b11, 2'b00, 1'b0);
`ifdef CLKEN_NCO_SQUARE_EN
    chk("s33_sq_rst", 32'(sq), 32'd0);
`endif
    for (int e = 1; e <= 20; e++) begin
      step($sformatf("s33_rel%0d", e), 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 2'b00, (e >= 16));
    end

    // Three-channel instance: index 3 is ignored, index 2 takes effect
    chk("d3_lock", 32'(lock3), 32'd1);
    chk("d3_idle", 32'(tick3), 32'd0);
    inc_wr3 = 1'b1; inc_ch3 = 2'd3; inc_val3 = 8'h80;
    @(posedge clk); #1;
    inc_wr3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("d3_oor%0d", c), 32'(tick3), 32'd0);
    end
    inc_wr3 = 1'b1; inc_ch3 = 2'd2; inc_val3 = 8'h80;
    @(posedge clk); #1;
    inc_wr3 = 1'b0;
    chk("d3_wr", 32'(tick3), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("d3_ch2_%0d", c), 32'(tick3), (c % 2 == 0) ? 32'h4 : 32'h0);
`ifdef CLKEN_NCO_SQUARE_EN
      if (c == 2) chk("d3_sq", 32'(sq3), 32'h4);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
